accumulator_mem_arbiter: RTL and testbench
==========================================

Name: accumulator_mem_arbiter

Overview:
- Shared operand-memory controller and round-robin arbiter for NUM_PROC accumulator_processor instances.
- Holds the operand pool as a LIFO of 32-bit words and services FETCH (pop) and SEND (push) transactions one processor at a time over the req/grant/op/signal/read/write handshake.
- Declares completion when one operand remains and no processor holds a partial operand; that operand is the accumulated sum.

Parameters:
- NUM_PROC, 4, number of attached processors (2..8).
- DEPTH, 32, operand memory depth in words.
- CNT_W, 6, width of the operand count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  push load_data into memory (IDLE only).
- load_data  in  32  operand to preload.
- start  in  1  one-cycle pulse: IDLE -> RUN.
- req  in  NUM_PROC  per-processor request.
- op  in  2*NUM_PROC  per-processor op; slice i = op[2i+1:2i]; 00 NOP, 01 FETCH, 10 SEND.
- write  in  32*NUM_PROC  per-processor result data; slice i = write[32i+31:32i].
- grant  out  NUM_PROC  one-hot grant.
- signal  out  NUM_PROC  one-cycle completion strobe to the granted processor.
- read  out  32  fetched operand, broadcast to all processors; valid when signal is high.
- count  out  CNT_W  operands currently in memory.
- done  out  1  high in DONE.
- result  out  32  final sum, valid when done is high.
- state  out  4  one-hot: IDLE 0001, RUN 0010, XFER 0100, DONE 1000.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; count=0; grant=0; signal=0; read=0; done=0; result=0.
  - Round-robin pointer = NUM_PROC-1, so processor 0 has first priority.
  - Hold flags cleared.
  - Reset mid-transaction abandons the transaction; memory contents are don't-care.
- IDLE:
  - load_valid with count<DEPTH: mem[count]<=load_data, count++.
  - load_valid with count==DEPTH: ignored.
  - start: go to RUN. If count==0, go to DONE with result=0.
  - req is ignored in IDLE.
- RUN (arbitration):
  - Processor i is eligible if req[i]=1 and either op=FETCH with count>0, or op=SEND with count<DEPTH. NOP and illegal op 11 are never eligible.
  - Search eligible processors starting at pointer+1 and wrapping around. The winner's grant bit is set at the next edge, the pointer is updated to the winner, and the FSM goes to XFER.
  - No eligible processor: stay in RUN.
  - If count==1 and all hold flags are 0: go to DONE with result<=mem[0]. This completion check has priority over arbitration.
- XFER:
  - The granted processor's op is sampled at the first XFER edge.
  - FETCH: read<=mem[count-1], count--, hold[i] toggles, signal[i]=1 for exactly one cycle.
  - SEND: mem[count]<=write slice i, count++, hold[i]<=0, signal[i]=1 for one cycle.
  - After the strobe, grant stays high until req[i] is sampled low. grant drops at that edge and the FSM returns to RUN.
  - If req[i] drops before the strobe, the transaction still completes. Processor op is held stable while req is high.
  - Latency: req high at edge k -> grant at k+1 -> signal at k+2 -> grant low one edge after req is sampled low. At most one transaction is in flight.
- hold[i]:
  - Set after the processor's first FETCH, cleared by its second FETCH (both operands held, add pending) or by SEND.
  - To track the pending add, a 2-bit per-processor outstanding counter is used: +1 per FETCH, reset to 0 on SEND. The completion check requires every counter to be 0.
- DONE: done=1 and result held; all grants 0. Only reset leaves DONE.
- Deadlock (every processor holding one operand with count==0) is not detected; the pool sizing is the system's responsibility.

Optional Feature:
- Macro ACC_ARB_STATS_EN.
- Defined: adds output txn_count[15:0], cleared on reset and incremented on each signal strobe (saturates at 16'hFFFF), plus output busy_cycles[15:0], counting cycles spent in XFER (saturating).
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Shared package accumulator_pkg holds:
  - op encodings NOP/FETCH/SEND;
  - the one-hot state constants for this block;
  - the data width constant 32.
- One sub-module, rr_arbiter: NUM_PROC eligible vector plus pointer in, one-hot winner plus valid out, combinational.

Test Plan:
- Load 5,7 then start; processor 0 does FETCH, FETCH, SEND 12 -> signal0 strobes with read=7 then 5; count goes 2,1,0,1; done=1 and result=12.
- Processors 0 and 2 request FETCH in the same cycle from reset -> proc 0 is granted first, proc 2 next; with proc 0 re-requesting, the order is 0,2,0 (round-robin).
- Load 1..8 (sum 36) with 4 processors running concurrently -> done with result=36; grant is always one-hot.
- FETCH request with count=0 while another processor holds operands -> no grant until SEND raises count to 1.
- Assert reset during XFER -> next cycle state=0001, count=0, grant=0, signal=0.
- start with an empty memory -> DONE on the next edge with result=0; load_valid at DEPTH=count is ignored.

Source files
------------

// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator operand-memory controller and its processors.
package accumulator_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_FETCH = 2'b01,
    OP_SEND  = 2'b10
  } op_e;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_RUN  = 4'b0010;
  localparam logic [3:0] ST_XFER = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;
endpackage

// File: rtl/accumulator_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester after ptr, wrapping around.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         winner,
  output logic                 valid
);
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && eligible[j]) begin
        winner[j] = 1'b1;
        valid     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/accumulator_mem_arbiter.sv
// LIFO operand pool shared by NUM_PROC accumulator processors, one transaction at a time.
// Optional build macro ACC_ARB_STATS_EN adds txn_count / busy_cycles counters.
module accumulator_mem_arbiter
  import accumulator_pkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int DEPTH    = 32,
  parameter int CNT_W    = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         start,
  input  logic [NUM_PROC-1:0]          req,
  input  logic [2*NUM_PROC-1:0]        op,
  input  logic [DATA_W*NUM_PROC-1:0]   write,
  output logic [NUM_PROC-1:0]          grant,
  output logic [NUM_PROC-1:0]          signal,
  output logic [DATA_W-1:0]            read,
  output logic [CNT_W-1:0]             count,
  output logic                         done,
  output logic [DATA_W-1:0]            result,
  output logic [3:0]                   state
`ifdef ACC_ARB_STATS_EN
  ,
  output logic [15:0]                  txn_count,
  output logic [15:0]                  busy_cycles
`endif
);
  localparam int PW = $clog2(NUM_PROC);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [1:0]          op_a [NUM_PROC];
  logic [DATA_W-1:0]   wr_a [NUM_PROC];
  logic [1:0]          outst [NUM_PROC];
  logic [NUM_PROC-1:0] eligible, win;
  logic                win_vld;
  logic [PW-1:0]       ptr, win_idx;
  logic                strobed;
  logic [3:0]          state_nx;
  logic [CNT_W-1:0]    cnt_m1;
  logic                room, avail, all_idle, finish, xfer_go;

  assign room    = count < CNT_W'(DEPTH);
  assign avail   = count != '0;
  assign cnt_m1  = count - CNT_W'(1);
  assign finish  = (count == CNT_W'(1)) && all_idle;
  assign xfer_go = (state == ST_XFER) && !strobed;

  for (genvar i = 0; i < NUM_PROC; i++) begin : g_lane
    assign op_a[i]     = op[2*i +: 2];
    assign wr_a[i]     = write[DATA_W*i +: DATA_W];
    assign eligible[i] = req[i] && ((op_a[i] == OP_FETCH && avail) ||
                                    (op_a[i] == OP_SEND  && room));
  end

  always_comb begin
    all_idle = 1'b1;
    for (int i = 0; i < NUM_PROC; i++)
      if (outst[i] != 2'd0) all_idle = 1'b0;
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PROC; i++)
      if (win[i]) win_idx = PW'(i);
  end

  rr_arbiter #(.N(NUM_PROC)) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (win),
    .valid    (win_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Completion outranks arbitration so a lone surviving operand ends the run.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = (count == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (finish) state_nx = ST_DONE;
               else if (win_vld) state_nx = ST_XFER;
      ST_XFER: if (strobed && !req[ptr]) state_nx = ST_RUN;
      ST_DONE: state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    done = (state == ST_DONE);
  end

  // Operand storage carries no reset; contents are meaningless until reloaded.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && load_valid && room)
      mem[count[AW-1:0]] <= load_data;
    else if (xfer_go && op_a[ptr] == OP_SEND && room)
      mem[count[AW-1:0]] <= wr_a[ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      grant   <= '0;
      signal  <= '0;
      read    <= '0;
      result  <= '0;
      ptr     <= PW'(NUM_PROC-1);
      strobed <= 1'b0;
      for (int i = 0; i < NUM_PROC; i++) outst[i] <= 2'd0;
    end else begin
      signal <= '0;
      case (state)
        ST_IDLE: begin
          if (load_valid && room) count <= count + CNT_W'(1);
          if (start && count == '0) result <= '0;
        end
        ST_RUN: begin
          if (finish) result <= mem[0];
          else if (win_vld) begin
            grant   <= win;
            ptr     <= win_idx;
            strobed <= 1'b0;
          end
        end
        ST_XFER: begin
          if (!strobed) begin
            strobed <= 1'b1;
            signal  <= grant;
            if (op_a[ptr] == OP_FETCH && avail) begin
              read       <= mem[cnt_m1[AW-1:0]];
              count      <= cnt_m1;
              outst[ptr] <= outst[ptr] + 2'd1;
            end else if (op_a[ptr] == OP_SEND && room) begin
              count      <= count + CNT_W'(1);
              outst[ptr] <= 2'd0;
            end
          end else if (!req[ptr]) begin
            grant <= '0;
          end
        end
        ST_DONE: grant <= '0;
        default: ;
      endcase
    end
  end

`ifdef ACC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      txn_count   <= '0;
      busy_cycles <= '0;
    end else begin
      if (xfer_go && txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
      if (state == ST_XFER && busy_cycles != 16'hFFFF) busy_cycles <= busy_cycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_accumulator_mem_arbiter.sv
// Directed and randomized checks of accumulator_mem_arbiter against a LIFO/sum model.
module tb_accumulator_mem_arbiter;
  import accumulator_pkg::*;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset, load_valid, start;
  logic [31:0]     load_data;
  logic [NP-1:0]   req, grant, signal;
  logic [2*NP-1:0] op;
  logic [32*NP-1:0] write;
  logic [31:0]     read, result;
  logic [5:0]      count;
  logic            done;
  logic [3:0]      state;
`ifdef ACC_ARB_STATS_EN
  logic [15:0]     txn_count, busy_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accumulator_mem_arbiter #(.NUM_PROC(NP), .DEPTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .start(start), .req(req), .op(op), .write(write), .grant(grant),
    .signal(signal), .read(read), .count(count), .done(done),
    .result(result), .state(state)
`ifdef ACC_ARB_STATS_EN
    , .txn_count(txn_count), .busy_cycles(busy_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
    req = '0; op = '0; write = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] v);
    load_valid = 1'b1; load_data = v;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic raise(input int p, input logic [1:0] o, input logic [31:0] wd);
    req[p] = 1'b1;
    op[2*p +: 2] = o;
    write[32*p +: 32] = wd;
  endtask

  task automatic wait_strobe(input int p, output logic [31:0] rd);
    int n = 0;
    do begin @(negedge clk); n++; end while (!signal[p] && n < 40);
    chk("strobe_seen", 32'(signal[p]), 32'd1);
    rd = read;
  endtask

  task automatic release_req(input int p);
    int n = 0;
    req[p] = 1'b0;
    op[2*p +: 2] = OP_NOP;
    do begin @(negedge clk); n++; end while (grant[p] && n < 10);
    chk("grant_drop", 32'(grant[p]), 32'd0);
  endtask

  task automatic xact(input int p, input logic [1:0] o, input logic [31:0] wd,
                      output logic [31:0] rd);
    raise(p, o, wd);
    wait_strobe(p, rd);
    release_req(p);
  endtask

  // Each model processor reserves two pool operands before its first FETCH so
  // the random run can never reach the all-holding deadlock.
  task automatic run_random(input int nops, input bit rnd_vals);
    logic [31:0] stk[$];
    logic [31:0] sum = 0;
    logic [31:0] a_v [NP];
    int          phase [NP];
    int          reserved = 0;
    int          cyc = 0;
    logic [31:0] v, e;
    do_reset();
    for (int i = 0; i < nops; i++) begin
      v = rnd_vals ? $urandom : 32'(i + 1);
      load_word(v);
      stk.push_back(v);
      sum += v;
    end
    for (int p = 0; p < NP; p++) begin phase[p] = 0; a_v[p] = '0; end
    pulse_start();
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      for (int p = 0; p < NP; p++) begin
        if (signal[p]) begin
          chk("sig_to_req", 32'(req[p]), 32'd1);
          if (phase[p] < 2) begin
            e = stk.pop_back();
            chk("rnd_read", read, e);
            if (phase[p] == 0) a_v[p] = e;
            else a_v[p] = a_v[p] + e;
            reserved--;
          end else begin
            stk.push_back(a_v[p]);
          end
          chk("rnd_count", 32'(count), 32'(stk.size()));
          phase[p] = (phase[p] + 1) % 3;
          req[p] = 1'b0;
          op[2*p +: 2] = OP_NOP;
        end else if (!req[p] && !grant[p] && $urandom_range(0, 3) == 0) begin
          if (phase[p] == 0) begin
            if (stk.size() - reserved >= 2) begin
              reserved += 2;
              raise(p, OP_FETCH, '0);
            end
          end else begin
            raise(p, (phase[p] == 1) ? OP_FETCH : OP_SEND, a_v[p]);
          end
        end
      end
    end
    repeat (2) @(negedge clk);
    chk("rnd_done", 32'(done), 32'd1);
    chk("rnd_result", result, sum);
    chk("rnd_final_cnt", 32'(count), 32'd1);
    chk("rnd_grant_done", 32'(grant), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;

    // reset state, then single-processor fetch/fetch/send
    do_reset();
    chk("rst_state", 32'(state), 32'(4'b0001));
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_signal", 32'(signal), 32'd0);
    chk("rst_read", read, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    load_word(32'd5);
    load_word(32'd7);
    chk("t1_load_cnt", 32'(count), 32'd2);
    pulse_start();
    chk("t1_run", 32'(state), 32'(4'b0010));
    xact(0, OP_FETCH, '0, rd);
    chk("t1_rd0", rd, 32'd7);
    chk("t1_cnt0", 32'(count), 32'd1);
    xact(0, OP_FETCH, '0, rd);
    chk("t1_rd1", rd, 32'd5);
    chk("t1_cnt1", 32'(count), 32'd0);
    xact(0, OP_SEND, 32'd12, rd);
    chk("t1_cnt2", 32'(count), 32'd1);
    repeat (2) @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_state", 32'(state), 32'(4'b1000));
    chk("t1_result", result, 32'd12);

    // round robin 0,2,0 with latency checks
    do_reset();
    for (int i = 1; i <= 4; i++) load_word(32'(i));
    pulse_start();
    raise(0, OP_FETCH, '0);
    raise(2, OP_FETCH, '0);
    @(negedge clk);
    chk("t2_grant_lat", 32'(grant), 32'(4'b0001));
    chk("t2_sig_early", 32'(signal), 32'd0);
    @(negedge clk);
    chk("t2_sig_lat", 32'(signal), 32'(4'b0001));
    chk("t2_rd0", read, 32'd4);
    @(negedge clk);
    chk("t2_sig_once", 32'(signal), 32'd0);
    chk("t2_grant_hold", 32'(grant), 32'(4'b0001));
    release_req(0);
    raise(0, OP_FETCH, '0);
    wait_strobe(2, rd);
    chk("t2_grant_p2", 32'(grant), 32'(4'b0100));
    chk("t2_rd1", rd, 32'd3);
    release_req(2);
    wait_strobe(0, rd);
    chk("t2_grant_p0", 32'(grant), 32'(4'b0001));
    chk("t2_rd2", rd, 32'd2);
    release_req(0);

    // FETCH stalls on an empty pool until a SEND refills it
    do_reset();
    for (int i = 1; i <= 3; i++) load_word(32'(i));
    pulse_start();
    xact(1, OP_FETCH, '0, rd);
    chk("t4_rd_p1", rd, 32'd3);
    xact(0, OP_FETCH, '0, rd);
    xact(0, OP_FETCH, '0, rd);
    chk("t4_empty", 32'(count), 32'd0);
    raise(1, OP_FETCH, '0);
    repeat (5) @(negedge clk);
    chk("t4_no_grant", 32'(grant), 32'd0);
    chk("t4_stay_run", 32'(state), 32'(4'b0010));
    raise(0, OP_SEND, 32'd3);
    wait_strobe(0, rd);
    chk("t4_refill", 32'(count), 32'd1);
    release_req(0);
    wait_strobe(1, rd);
    chk("t4_rd_late", rd, 32'd3);
    release_req(1);
    xact(1, OP_SEND, 32'd6, rd);
    repeat (2) @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_result", result, 32'd6);

    // reset in the middle of a transfer
    do_reset();
    load_word(32'd5);
    load_word(32'd7);
    pulse_start();
    raise(0, OP_FETCH, '0);
    @(negedge clk);
    chk("t5_in_xfer", 32'(state), 32'(4'b0100));
    reset = 1'b1;
    @(negedge clk);
    chk("t5_state", 32'(state), 32'(4'b0001));
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_signal", 32'(signal), 32'd0);
    reset = 1'b0;
    req = '0; op = '0;

    // empty start and load overflow
    do_reset();
    pulse_start();
    chk("t6_state", 32'(state), 32'(4'b1000));
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_result", result, 32'd0);
    do_reset();
    for (int i = 0; i < 33; i++) load_word($urandom);
    chk("t6_full", 32'(count), 32'd32);
    chk("t6_idle", 32'(state), 32'(4'b0001));

    // concurrent random processors
    run_random(8, 1'b0);
    for (int r = 0; r < 3; r++) run_random($urandom_range(2, 12), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
